// File: rtl/tcpc_goodcrc_tx.sv
// GoodCRC transmit stage: builds the 2-byte GoodCRC header, streams it to the PHY and reports complete/discard to rx.
// Header latched on request; low byte first; all outputs registered.
module tcpc_goodcrc_tx #(
    parameter logic [1:0]  SPEC_REV     = 2'b10,
    parameter int unsigned IDLE_TIMEOUT = 64,
    parameter int unsigned DONE_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset_L,
    input  logic       Send_GoodCRC_message_to_PHY,
    input  logic [2:0] msg_id,
    input  logic       port_power_role,
    input  logic       port_data_role,
    input  logic       bus_idle,
    input  logic       message_received_from_phy,
    input  logic       phy_tx_ready,
    input  logic       phy_tx_done,
    output logic       phy_tx_valid,
    output logic [7:0] phy_tx_data,
    output logic       phy_tx_last,
    output logic       GoodCRC_Transmission_complete,
    output logic       GoodCRC_Message_discarded_bus_Idle,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_IDLE,
        S_SEND_LO,
        S_SEND_HI,
        S_WAIT_DONE
    } state_t;

    localparam logic [7:0] IDLE_LAST = 8'(IDLE_TIMEOUT - 1);
    localparam logic [7:0] DONE_LAST = 8'(DONE_TIMEOUT - 1);

    state_t      state_q;
    logic [15:0] hdr_q;
    logic [15:0] hdr_d;
    logic [7:0]  cnt_q;
    logic        valid_q;
    logic [7:0]  data_q;
    logic        last_q;
    logic        complete_q;
    logic        discard_q;
    logic        busy_q;

    // GoodCRC control message: zero data objects, extended bit clear.
    assign hdr_d = {1'b0, 3'b000, msg_id, port_power_role, SPEC_REV, port_data_role, 5'b00001};

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q    <= S_IDLE;
            hdr_q      <= 16'h0000;
            cnt_q      <= 8'h00;
            valid_q    <= 1'b0;
            data_q     <= 8'h00;
            last_q     <= 1'b0;
            complete_q <= 1'b0;
            discard_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            complete_q <= 1'b0;
            discard_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (Send_GoodCRC_message_to_PHY) begin
                        hdr_q   <= hdr_d;
                        cnt_q   <= 8'h00;
                        busy_q  <= 1'b1;
                        state_q <= S_WAIT_IDLE;
                    end
                end
                S_WAIT_IDLE: begin
                    // A new incoming message preempts the GoodCRC even if the bus looks idle.
                    if (message_received_from_phy) begin
                        discard_q <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= S_IDLE;
                    end else if (bus_idle) begin
                        valid_q <= 1'b1;
                        data_q  <= hdr_q[7:0];
                        last_q  <= 1'b0;
                        state_q <= S_SEND_LO;
                    end else if (cnt_q == IDLE_LAST) begin
                        discard_q <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_SEND_LO: begin
                    if (phy_tx_ready) begin
                        data_q  <= hdr_q[15:8];
                        last_q  <= 1'b1;
                        state_q <= S_SEND_HI;
                    end
                end
                S_SEND_HI: begin
                    if (phy_tx_ready) begin
                        valid_q <= 1'b0;
                        data_q  <= 8'h00;
                        last_q  <= 1'b0;
                        cnt_q   <= 8'h00;
                        state_q <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (phy_tx_done) begin
                        complete_q <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= S_IDLE;
                    end else if (cnt_q == DONE_LAST) begin
                        discard_q <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    data_q  <= 8'h00;
                    last_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign phy_tx_valid                       = valid_q;
    assign phy_tx_data                        = data_q;
    assign phy_tx_last                        = last_q;
    assign GoodCRC_Transmission_complete      = complete_q;
    assign GoodCRC_Message_discarded_bus_Idle = discard_q;
    assign busy                               = busy_q;

endmodule

// File: tb/tb_tcpc_goodcrc_tx.sv
// Scoreboard bench for tcpc_goodcrc_tx: directed stimulus pushes expected PHY bytes and completion events.
module tb_tcpc_goodcrc_tx;

    logic       clk;
    logic       reset_L;
    logic       send_req;
    logic [2:0] msg_id;
    logic       port_power_role;
    logic       port_data_role;
    logic       bus_idle;
    logic       mrx;
    logic       phy_tx_ready;
    logic       phy_tx_done;
    logic       phy_tx_valid;
    logic [7:0] phy_tx_data;
    logic       phy_tx_last;
    logic       complete;
    logic       discard;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int nxfer  = 0;
    logic [10:0] sb_q[$];

    localparam logic [1:0] K_BYTE = 2'd0;
    localparam logic [1:0] K_CMPL = 2'd1;
    localparam logic [1:0] K_DISC = 2'd2;

    tcpc_goodcrc_tx #(
        .SPEC_REV    (2'b10),
        .IDLE_TIMEOUT(8),
        .DONE_TIMEOUT(16)
    ) dut (
        .clk                               (clk),
        .reset_L                           (reset_L),
        .Send_GoodCRC_message_to_PHY       (send_req),
        .msg_id                            (msg_id),
        .port_power_role                   (port_power_role),
        .port_data_role                    (port_data_role),
        .bus_idle                          (bus_idle),
        .message_received_from_phy         (mrx),
        .phy_tx_ready                      (phy_tx_ready),
        .phy_tx_done                       (phy_tx_done),
        .phy_tx_valid                      (phy_tx_valid),
        .phy_tx_data                       (phy_tx_data),
        .phy_tx_last                       (phy_tx_last),
        .GoodCRC_Transmission_complete     (complete),
        .GoodCRC_Message_discarded_bus_Idle(discard),
        .busy                              (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] d, input logic l);
        sb_q.push_back({K_BYTE, l, d});
    endtask

    task automatic push_evt(input logic [1:0] k);
        sb_q.push_back({k, 1'b0, 8'h00});
    endtask

    task automatic sb_compare(input logic [10:0] act);
        logic [10:0] exp;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: got event 0x%0h, expected none", act);
        end else begin
            exp = sb_q.pop_front();
            check("sb_event", 16'(act), 16'(exp));
        end
    endtask

    // Monitor: every PHY transfer and completion pulse is checked against the queue.
    always @(negedge clk) begin
        if (reset_L) begin
            check("pulse_overlap", 16'(complete & discard), 16'd0);
            if (phy_tx_valid && phy_tx_ready) begin
                nxfer++;
                sb_compare({K_BYTE, phy_tx_last, phy_tx_data});
            end
            if (complete) sb_compare({K_CMPL, 1'b0, 8'h00});
            if (discard) sb_compare({K_DISC, 1'b0, 8'h00});
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic [2:0] id, input logic pr, input logic dr);
        msg_id          = id;
        port_power_role = pr;
        port_data_role  = dr;
        send_req        = 1'b1;
        tick();
        send_req        = 1'b0;
    endtask

    task automatic done_pulse(input string name);
        phy_tx_done = 1'b1;
        tick();
        phy_tx_done = 1'b0;
        check({name, "_complete"}, 16'(complete), 16'd1);
        check({name, "_busy_off"}, 16'(busy), 16'd0);
    endtask

    initial begin
        int n;
        int x0;
        reset_L = 1'b0; send_req = 1'b0; msg_id = 3'd0; port_power_role = 1'b0;
        port_data_role = 1'b0; bus_idle = 1'b0; mrx = 1'b0; phy_tx_ready = 1'b0; phy_tx_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_outputs", 16'({phy_tx_valid, phy_tx_data, phy_tx_last, complete, discard, busy}), 16'd0);
        reset_L = 1'b1;
        tick();

        // Basic transfer, minimum latency
        bus_idle = 1'b1; phy_tx_ready = 1'b1;
        push_byte(8'h81, 1'b0); push_byte(8'h0B, 1'b1); push_evt(K_CMPL);
        request(3'b101, 1'b1, 1'b0);
        check("s1_busy_n1", 16'(busy), 16'd1);
        check("s1_valid_n1", 16'(phy_tx_valid), 16'd0);
        tick();
        check("s1_lo", 16'({phy_tx_valid, phy_tx_last, phy_tx_data}), 16'h281);
        tick();
        check("s1_hi", 16'({phy_tx_valid, phy_tx_last, phy_tx_data}), 16'h30B);
        tick();
        check("s1_wait_done", 16'({busy, phy_tx_valid}), 16'h2);
        done_pulse("s1");
        tick();
        check("s1_pulse_width", 16'(complete), 16'd0);

        // Backpressure: 3 stalled cycles per byte
        phy_tx_ready = 1'b0;
        push_byte(8'hA1, 1'b0); push_byte(8'h0F, 1'b1); push_evt(K_CMPL);
        x0 = nxfer;
        request(3'b111, 1'b1, 1'b1);
        tick();
        for (int i = 0; i < 4; i++) begin
            phy_tx_ready = (i == 3);
            check("s2_lo_hold", 16'({phy_tx_valid, phy_tx_last, phy_tx_data}), 16'h2A1);
            tick();
        end
        phy_tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            phy_tx_ready = (i == 3);
            check("s2_hi_hold", 16'({phy_tx_valid, phy_tx_last, phy_tx_data}), 16'h30F);
            tick();
        end
        phy_tx_ready = 1'b1;
        check("s2_valid_off", 16'(phy_tx_valid), 16'd0);
        check("s2_xfers", 16'(nxfer - x0), 16'd2);
        done_pulse("s2");
        tick();

        // Bus never idle: idle timeout
        bus_idle = 1'b0;
        push_evt(K_DISC);
        request(3'b000, 1'b0, 1'b0);
        n = 0;
        while (!discard && n < 50) begin
            n++;
            tick();
        end
        check("s3_idle_cycles", 16'(n), 16'd8);
        check("s3_busy_off", 16'(busy), 16'd0);
        tick();
        check("s3_pulse_width", 16'(discard), 16'd0);

        // Incoming message together with bus_idle in WAIT_IDLE
        push_evt(K_DISC);
        request(3'b010, 1'b0, 1'b1);
        tick(); tick();
        mrx = 1'b1; bus_idle = 1'b1;
        tick();
        mrx = 1'b0; bus_idle = 1'b0;
        check("s4a_discard", 16'({discard, busy, phy_tx_valid}), 16'h4);
        tick();

        // Incoming message during SEND_HI is ignored
        bus_idle = 1'b1; phy_tx_ready = 1'b1;
        push_byte(8'hA1, 1'b0); push_byte(8'h04, 1'b1); push_evt(K_CMPL);
        request(3'b010, 1'b0, 1'b1);
        tick();
        tick();
        check("s4b_hi", 16'({phy_tx_valid, phy_tx_last, phy_tx_data}), 16'h304);
        mrx = 1'b1;
        tick();
        mrx = 1'b0;
        check("s4b_committed", 16'({busy, discard}), 16'h2);
        done_pulse("s4b");
        tick();

        // Done timeout
        push_byte(8'h81, 1'b0); push_byte(8'h0B, 1'b1); push_evt(K_DISC);
        request(3'b101, 1'b1, 1'b0);
        tick(); tick(); tick();
        n = 0;
        while (!discard && n < 100) begin
            n++;
            tick();
        end
        check("s5_done_cycles", 16'(n), 16'd16);
        check("s5_busy_off", 16'(busy), 16'd0);
        tick();

        // Reset during SEND_LO
        phy_tx_ready = 1'b0;
        request(3'b101, 1'b1, 1'b0);
        tick();
        check("s5r_pre_valid", 16'(phy_tx_valid), 16'd1);
        reset_L = 1'b0;
        #1;
        check("s5r_async_drop", 16'({phy_tx_valid, busy, phy_tx_data}), 16'd0);
        tick(); tick();
        reset_L = 1'b1;
        phy_tx_ready = 1'b1;
        push_byte(8'h81, 1'b0); push_byte(8'h00, 1'b1); push_evt(K_CMPL);
        request(3'b000, 1'b0, 1'b0);
        tick();
        check("s5r_lo", 16'({phy_tx_valid, phy_tx_last, phy_tx_data}), 16'h281);
        tick();
        check("s5r_hi", 16'({phy_tx_valid, phy_tx_last, phy_tx_data}), 16'h300);
        tick();
        done_pulse("s5r");
        tick();

        // Request while busy and stray done in IDLE
        bus_idle = 1'b0;
        push_byte(8'h81, 1'b0); push_byte(8'h0B, 1'b1); push_evt(K_CMPL);
        request(3'b101, 1'b1, 1'b0);
        tick();
        request(3'b011, 1'b0, 1'b1);
        bus_idle = 1'b1;
        tick();
        check("s6_lo", 16'({phy_tx_valid, phy_tx_last, phy_tx_data}), 16'h281);
        tick();
        check("s6_hi", 16'({phy_tx_valid, phy_tx_last, phy_tx_data}), 16'h30B);
        tick();
        done_pulse("s6");
        tick();
        phy_tx_done = 1'b1;
        tick();
        phy_tx_done = 1'b0;
        check("s6_stray_done", 16'({busy, phy_tx_valid, complete, discard}), 16'd0);
        tick();
        check("s6_still_idle", 16'({busy, complete, discard}), 16'd0);

        tick(); tick();
        check("sb_empty", 16'(sb_q.size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
